mem_arbiter: RTL

Sequencer that shares the single main-memory port between the instruction cache line-fill path and the data cache fill/write-back path. Sits between both caches and the memory model. Accepts one outstanding request at a time, forwards it to memory, holds the memory request stable until memory completes, and returns the line or write acknowledgement to the owning requester with a one-cycle ready pulse.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, the two cache requesters and the memory port.
// The master modport is the arbiter's view; slave is the caches + memory side.
//
// Handshake: i_req/d_req are levels held by the requester until its one-cycle
// i_ready/d_ready pulse. mem_req is a level held by the arbiter until memory
// answers with a one-cycle mem_ready pulse, which also qualifies mem_rline.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_line;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wline;
  logic [LINE_W-1:0] d_line;
  logic              d_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wline;
  logic [LINE_W-1:0] mem_rline;
  logic              mem_ready;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wline, mem_rline, mem_ready,
    output i_line, i_ready, d_line, d_ready, mem_req, mem_we, mem_addr, mem_wline
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wline, mem_rline, mem_ready,
    input  i_line, i_ready, d_line, d_ready, mem_req, mem_we, mem_addr, mem_wline
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the iCache line-fill path
// and the dCache fill/write-back path, one outstanding access at a time.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests
// (last-grant bit, reset to icache); otherwise the dCache has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.master bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   grant_i, grant_d, pick_d;
  logic   done_i, done_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 0 = icache was granted last, 1 = dcache was granted last
  logic last_d_q;

  // Remember who won the most recent grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         last_d_q <= 1'b0;
    else if (grant_d) last_d_q <= 1'b1;
    else if (grant_i) last_d_q <= 1'b0;
  end

  // On a tie the requester not granted last wins.
  assign pick_d = bus.d_req && (!bus.i_req || !last_d_q);
`else
  assign pick_d = bus.d_req;
`endif

  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state, grant and completion decisions.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done_i  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          grant_d = 1'b1;
          state_d = DGNT;
        end else if (bus.i_req) begin
          grant_i = 1'b1;
          state_d = IGNT;
        end
      end
      IGNT: begin
        if (bus.mem_ready) begin
          done_i  = 1'b1;
          state_d = DONE;
        end
      end
      DGNT: begin
        if (bus.mem_ready) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      // One dead cycle so the owner can drop its request after its pulse.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory request registers and returned lines / ready pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wline <= '0;
      bus.i_line    <= '0;
      bus.d_line    <= '0;
      bus.i_ready   <= 1'b0;
      bus.d_ready   <= 1'b0;
    end else begin
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      if (grant_d) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_addr  <= {bus.d_addr[ADDR_W-1:4], 4'b0000};
        bus.mem_wline <= bus.d_wline;
      end else if (grant_i) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= {bus.i_addr[ADDR_W-1:4], 4'b0000};
        bus.mem_wline <= '0;
      end
      if (done_i) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
        bus.i_line  <= bus.mem_rline;
        bus.i_ready <= 1'b1;
      end
      if (done_d) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
        // A write-back returns no data, so the fill line keeps its value.
        if (!bus.mem_we) bus.d_line <= bus.mem_rline;
        bus.d_ready <= 1'b1;
      end
    end
  end

endmodule
